// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit:
// FSM states, opcodes, ALUOp / ALUSrcB / PCSource codes and the control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH        = 4'd0,
    S_DECODE       = 4'd1,
    S_MEM_ADDR     = 4'd2,
    S_MEM_READ     = 4'd3,
    S_MEM_WB       = 4'd4,
    S_MEM_WRITE    = 4'd5,
    S_EXECUTE      = 4'd6,
    S_R_COMPLETE   = 4'd7,
    S_BRANCH       = 4'd8,
    S_JUMP         = 4'd9,
    S_IMM_EXEC     = 4'd10,
    S_IMM_COMPLETE = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All datapath controls plus the two status pulses, bundled so the
  // decoder hands one value back to the top.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI) || (op == OP_ANDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Moore output decode: maps the current state (plus latched opcode and the
// memory handshake) to the datapath control word. Reset forces everything low
// so no partial register/memory/PC write can leak out mid-instruction.
module mc_ctrl_outputs
  import mc_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [5:0] i_op,
  input  logic [5:0] i_op_q,
  input  logic       i_mem_ready,
  input  logic       i_reset,
  output ctrl_t      o_ctrl
);

  // Per-state control word; unlisted fields and unused states stay 0.
  always_comb begin
    o_ctrl = '0;
    if (!i_reset) begin
      case (i_state)
        S_FETCH: begin
          o_ctrl.mem_read  = 1'b1;
          o_ctrl.alu_src_b = SRCB_FOUR;
          o_ctrl.alu_op    = ALUOP_ADD;
          o_ctrl.ir_write  = i_mem_ready;
          o_ctrl.pc_write  = i_mem_ready;
        end
        S_DECODE: begin
          o_ctrl.alu_src_b  = SRCB_IMM_SH;
          o_ctrl.alu_op     = ALUOP_ADD;
          o_ctrl.illegal_op = !is_legal_op(i_op);
        end
        S_MEM_ADDR: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_IMM;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          o_ctrl.mem_read = 1'b1;
          o_ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          // MemWrite is held until the memory accepts; done only on that cycle.
          o_ctrl.mem_write  = 1'b1;
          o_ctrl.i_or_d     = 1'b1;
          o_ctrl.instr_done = i_mem_ready;
        end
        S_EXECUTE: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_B;
          o_ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_R_COMPLETE: begin
          o_ctrl.reg_dst    = 1'b1;
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          o_ctrl.alu_src_a     = 1'b1;
          o_ctrl.alu_src_b     = SRCB_B;
          o_ctrl.alu_op        = ALUOP_SUB;
          o_ctrl.pc_write_cond = 1'b1;
          o_ctrl.pc_source     = PCSRC_ALUOUT;
          o_ctrl.branch_ne     = (i_op_q == OP_BNE);
          o_ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          o_ctrl.pc_write   = 1'b1;
          o_ctrl.pc_source  = PCSRC_JUMP;
          o_ctrl.instr_done = 1'b1;
        end
        S_IMM_EXEC: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_IMM;
          o_ctrl.alu_op    = (i_op_q == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
        end
        S_IMM_COMPLETE: begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control: state register, latched opcode,
// retired-instruction counter and next-state logic. Output decode lives in
// mc_ctrl_outputs.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state_dbg
);

  state_e           r_state;
  state_e           w_state_next;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_mem_ready;
  ctrl_t            w_ctrl;

  // With wait states disabled the memory is assumed to answer every cycle.
  assign w_mem_ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  // State, opcode latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_op_q      <= 6'd0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) begin
        r_op_q <= Op;
      end
      if (w_ctrl.instr_done) begin
        r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state: DECODE dispatches on the live opcode, later states on op_q.
  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_state_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:     w_state_next = S_MEM_ADDR;
          OP_R:             w_state_next = S_EXECUTE;
          OP_BEQ, OP_BNE:   w_state_next = S_BRANCH;
          OP_J:             w_state_next = S_JUMP;
          OP_ADDI, OP_ANDI: w_state_next = S_IMM_EXEC;
          default:          w_state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_state_next = (r_op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_state_next = w_mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_state_next = w_mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_state_next = S_R_COMPLETE;
      S_IMM_EXEC:  w_state_next = S_IMM_COMPLETE;
      default:     w_state_next = S_FETCH;
    endcase
  end

  mc_ctrl_outputs u_outputs (
    .i_state     (r_state),
    .i_op        (Op),
    .i_op_q      (r_op_q),
    .i_mem_ready (w_mem_ready),
    .i_reset     (reset),
    .o_ctrl      (w_ctrl)
  );

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign BranchNe    = w_ctrl.branch_ne;
  assign IorD        = w_ctrl.i_or_d;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign IRWrite     = w_ctrl.ir_write;
  assign RegDst      = w_ctrl.reg_dst;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign instr_done  = w_ctrl.instr_done;
  assign illegal_op  = w_ctrl.illegal_op;
  assign instr_cnt   = r_instr_cnt;
  assign state_dbg   = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Testbench for mc_main_ctrl: directed scenarios followed by random
// instruction streams, checked cycle by cycle against an instruction-level
// reference (per-opcode step sequences and the control table).
module tb_mc_main_ctrl;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ANDI = 6'b001100;

  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mr, mw, m2r, irw, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       done, ill;
  } cw_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] instr_cnt;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_model = 0;
  int mw_seen  = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  mc_main_ctrl #(.CNT_W(4), .MEM_WAIT_EN(1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .instr_cnt(instr_cnt), .state_dbg(state_dbg)
  );

  function automatic logic legal(input logic [5:0] op);
    return op inside {T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI, T_ANDI};
  endfunction

  function automatic logic rr();
    return 1'($urandom);
  endfunction

  // Expected control word for a given step of an instruction.
  function automatic cw_t exp_ctrl(input int st, input logic [5:0] ins,
                                   input logic [5:0] op_in, input logic rdy);
    cw_t c;
    c = '0;
    case (st)
      0:  begin c.mr = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      1:  begin c.srcb = 2'b11; c.ill = !legal(op_in); end
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mr = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; c.done = 1; end
      5:  begin c.mw = 1; c.iord = 1; c.done = rdy; end
      6:  begin c.srca = 1; c.aluop = 2'b10; end
      7:  begin c.rdst = 1; c.rw = 1; c.done = 1; end
      8:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01;
                c.bne = (ins == T_BNE); c.done = 1; end
      9:  begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
      10: begin c.srca = 1; c.srcb = 2'b10; c.aluop = (ins == T_ANDI) ? 2'b11 : 2'b00; end
      11: begin c.rw = 1; c.done = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic cw_t observed();
    return {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
            IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
            instr_done, illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of an instruction: drive, settle, compare, advance model.
  task automatic step(input logic [5:0] ins, input int st, input logic rdy);
    cw_t e;
    cw_t o;
    @(negedge clk);
    reset = 1'b0;
    Op = (st == 1) ? ins : 6'($urandom);
    mem_ready = rdy;
    #1;
    e = exp_ctrl(st, ins, Op, rdy);
    o = observed();
    chk($sformatf("state op=%b", ins), 32'(state_dbg), 32'(st));
    chk($sformatf("ctrl op=%b st=%0d", ins, st), 32'(o), 32'(e));
    chk("instr_cnt", 32'(instr_cnt), 32'(cnt_model));
    if (MemWrite) mw_seen++;
    if (instr_done) done_seen++;
    if (e.done) cnt_model = (cnt_model + 1) % 16;
    $display("t=%0t op=%b st=%0d rdy=%0b ctrl=%h cnt=%0d", $time, Op, state_dbg, rdy, o, instr_cnt);
  endtask

  task automatic rst_step(input bit chk_cnt);
    @(negedge clk);
    reset = 1'b1;
    Op = 6'($urandom);
    mem_ready = rr();
    #1;
    chk("reset ctrl", 32'(observed()), 32'd0);
    chk("reset state", 32'(state_dbg), 32'd0);
    if (chk_cnt) chk("reset cnt", 32'(instr_cnt), 32'd0);
    cnt_model = 0;
    $display("t=%0t reset ctrl=%h st=%0d", $time, observed(), state_dbg);
  endtask

  // Whole instruction: fw FETCH wait cycles, mw data-memory wait cycles.
  task automatic run_instr(input logic [5:0] ins, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(ins, 0, 1'b0);
    step(ins, 0, 1'b1);
    step(ins, 1, rr());
    case (ins)
      T_LW: begin
        step(ins, 2, rr());
        for (int i = 0; i < mw; i++) step(ins, 3, 1'b0);
        step(ins, 3, 1'b1);
        step(ins, 4, rr());
      end
      T_SW: begin
        step(ins, 2, rr());
        for (int i = 0; i < mw; i++) step(ins, 5, 1'b0);
        step(ins, 5, 1'b1);
      end
      T_R:            begin step(ins, 6, rr());  step(ins, 7, rr());  end
      T_ADDI, T_ANDI: begin step(ins, 10, rr()); step(ins, 11, rr()); end
      T_BEQ, T_BNE:   step(ins, 8, rr());
      T_J:            step(ins, 9, rr());
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] pool [12];
    pool = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI, T_ANDI,
             6'b111111, 6'b001101, 6'b100000, 6'b000001};
    reset = 1'b1;
    Op = 6'd0;
    mem_ready = 1'b0;

    // Reset for three cycles, then lw with no waits.
    rst_step(1'b0);
    rst_step(1'b1);
    rst_step(1'b1);
    run_instr(T_LW, 0, 0);

    // sw stalled two cycles in MEM_WRITE: one write burst, one done pulse.
    mw_seen = 0;
    done_seen = 0;
    run_instr(T_SW, 0, 2);
    chk("sw MemWrite cycles", 32'(mw_seen), 32'd3);
    chk("sw instr_done pulses", 32'(done_seen), 32'd1);

    run_instr(T_R, 0, 0);
    run_instr(T_ANDI, 1, 0);
    run_instr(T_BNE, 0, 0);
    run_instr(T_BEQ, 0, 0);

    // Illegal opcode: two cycles, counter unchanged.
    done_seen = 0;
    run_instr(6'b111111, 0, 0);
    chk("illegal done pulses", 32'(done_seen), 32'd0);

    // Reset in the middle of a stalled lw read.
    step(T_LW, 0, 1'b1);
    step(T_LW, 1, rr());
    step(T_LW, 2, rr());
    step(T_LW, 3, 1'b0);
    rst_step(1'b0);
    rst_step(1'b1);

    // Sixteen jumps wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) run_instr(T_J, 0, 0);
    step(T_ADDI, 0, 1'b0);
    chk("cnt wrap", 32'(instr_cnt), 32'd0);

    // Random instruction stream with random wait states.
    for (int i = 0; i < 60; i++) begin
      run_instr(pool[$urandom_range(0, 11)], $urandom_range(0, 2), $urandom_range(0, 2));
    end
    step(T_J, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
